// File: rtl/mem_stage_responder.sv
// mem_stage_responder: MEM-stage data memory with fixed access latency that
// freezes the pipeline until each access completes and then pulses ready.
module mem_stage_responder #(
    parameter int          WAIT_CYCLES = 4,
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int          DEPTH       = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] ALU_Res,
    input  logic [31:0] Val_RM,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        freeze
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d, both_q, both_d, err_q, err_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [31:0] mem [DEPTH];
    logic [31:0] off;
    logic [AW-1:0] idx;
    logic        req, in_range, misaligned, mem_we;
    always_comb begin
        req        = MEM_R_EN | MEM_W_EN;
        off        = addr_q - ADDR_BASE;
        idx        = off[AW+1:2];
        in_range   = off < 32'(4 * DEPTH);
        misaligned = addr_q[1:0] != 2'b00;
        mem_we     = state_q == BUSY && req && cnt_q == 8'd0 && wr_q && in_range;
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        both_d     = both_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                state_d = BUSY;
                wr_d    = MEM_W_EN;
                both_d  = MEM_R_EN & MEM_W_EN;
                addr_d  = ALU_Res;
                wdata_d = Val_RM;
                cnt_d   = 8'(WAIT_CYCLES - 1);
            end
            BUSY: if (!req) state_d = IDLE;
                else if (cnt_q == 8'd0) begin
                    state_d = DONE;
                    err_d   = !in_range | misaligned | both_q;
                    rdata_d = wr_q ? rdata_q : (in_range ? mem[idx] : 32'd0);
                end else cnt_d = cnt_q - 8'd1;
            default: state_d = IDLE;
        endcase
        // Gated by reset so the stall releases the instant reset asserts.
        freeze = rst & req & (state_q != DONE);
        ready  = state_q == DONE;
        err    = err_q;
        rdata  = rdata_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            both_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            both_q  <= both_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= wdata_q;
    end
endmodule

// File: tb/tb_mem_stage_responder.sv
// tb_mem_stage_responder: directed checks of latency, range/alignment errors,
// abort, reset and back-to-back accesses.
module tb_mem_stage_responder;
    logic        clk = 1'b0, rst = 1'b0;
    logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
    logic [31:0] alu_res = '0, val_rm = '0;
    logic [31:0] rdata;
    logic        ready, err, freeze;
    logic        r1 = 1'b0, w1 = 1'b0;
    logic [31:0] a1 = '0, d1 = '0;
    logic [31:0] rdata1;
    logic        ready1, err1, freeze1;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_stage_responder #(.WAIT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .MEM_R_EN(mem_r_en), .MEM_W_EN(mem_w_en),
        .ALU_Res(alu_res), .Val_RM(val_rm), .rdata(rdata), .ready(ready),
        .err(err), .freeze(freeze)
    );

    mem_stage_responder #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .MEM_R_EN(r1), .MEM_W_EN(w1),
        .ALU_Res(a1), .Val_RM(d1), .rdata(rdata1), .ready(ready1),
        .err(err1), .freeze(freeze1)
    );

    // Starts at a negedge; holds the request until the cycle after ready.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int fz, output int at, output logic e);
        fz = 0; at = -1; e = 1'b0;
        mem_r_en = r; mem_w_en = w; alu_res = a; val_rm = d;
        for (int c = 0; c < 20 && at < 0; c++) begin
            #1;
            if (freeze) fz++;
            if (ready) begin at = c; e = err; end
            @(negedge clk);
        end
        mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    task automatic test_reset;
        mem_r_en = 1'b1; alu_res = 32'd1028;
        #1;
        total++; if (freeze !== 1'b0) begin bad++; $display("FAIL rst_freeze got=%b want=0", freeze); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", ready); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
        mem_r_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        int fz, at; logic e;
        access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, fz, at, e);
        total++; if (fz !== 5) begin bad++; $display("FAIL wr_freeze got=%0d want=5", fz); end
        total++; if (at !== 5) begin bad++; $display("FAIL wr_ready_cycle got=%0d want=5", at); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", e); end
        access(1'b1, 1'b0, 32'd1028, 32'h0, fz, at, e);
        total++; if (fz !== 5) begin bad++; $display("FAIL rd_freeze got=%0d want=5", fz); end
        total++; if (at !== 5) begin bad++; $display("FAIL rd_ready_cycle got=%0d want=5", at); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL rd_err got=%b want=0", e); end
        total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h want=deadbeef", rdata); end
    endtask

    task automatic test_range;
        int fz, at; logic e;
        access(1'b0, 1'b1, 32'd1024, 32'hA5A5A5A5, fz, at, e);
        access(1'b0, 1'b1, 32'd1276, 32'h11112222, fz, at, e);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL top_wr_err got=%b want=0", e); end
        access(1'b1, 1'b0, 32'd1276, 32'h0, fz, at, e);
        total++; if (rdata !== 32'h11112222 || e !== 1'b0) begin bad++; $display("FAIL top_rd got=%h/%b want=11112222/0", rdata, e); end
        access(1'b0, 1'b1, 32'd1280, 32'h33333333, fz, at, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_wr_err got=%b want=1", e); end
        total++; if (rdata !== 32'h11112222) begin bad++; $display("FAIL wr_keeps_rdata got=%h want=11112222", rdata); end
        access(1'b1, 1'b0, 32'd1024, 32'h0, fz, at, e);
        total++; if (rdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL oor_wr_no_alias got=%h want=a5a5a5a5", rdata); end
        access(1'b1, 1'b0, 32'd1020, 32'h0, fz, at, e);
        total++; if (rdata !== 32'd0 || e !== 1'b1) begin bad++; $display("FAIL below_base got=%h/%b want=0/1", rdata, e); end
        access(1'b1, 1'b0, 32'd1029, 32'h0, fz, at, e);
        total++; if (rdata !== 32'hDEADBEEF || e !== 1'b1) begin bad++; $display("FAIL misaligned_rd got=%h/%b want=deadbeef/1", rdata, e); end
        access(1'b1, 1'b1, 32'd1032, 32'h0BADF00D, fz, at, e);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL both_err got=%b want=1", e); end
        access(1'b1, 1'b0, 32'd1032, 32'h0, fz, at, e);
        total++; if (rdata !== 32'h0BADF00D || e !== 1'b0) begin bad++; $display("FAIL both_is_write got=%h/%b want=0badf00d/0", rdata, e); end
    endtask

    task automatic test_abort;
        int fz, at, pulses; logic e;
        pulses = 0;
        mem_r_en = 1'b1; alu_res = 32'd1024;
        repeat (2) @(negedge clk);
        mem_r_en = 1'b0;
        #1;
        total++; if (freeze !== 1'b0) begin bad++; $display("FAIL abort_freeze got=%b want=0", freeze); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            if (ready) pulses++;
        end
        @(negedge clk);
        total++; if (pulses !== 0) begin bad++; $display("FAIL abort_ready got=%0d pulses want=0", pulses); end
        total++; if (rdata !== 32'h0BADF00D) begin bad++; $display("FAIL abort_rdata got=%h want=0badf00d", rdata); end
        access(1'b1, 1'b0, 32'd1028, 32'h0, fz, at, e);
        total++; if (at !== 5 || rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL after_abort got=%0d/%h want=5/deadbeef", at, rdata); end
    endtask

    task automatic test_reset_busy;
        int fz, at; logic e;
        mem_w_en = 1'b1; alu_res = 32'd1032; val_rm = 32'h77777777;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL mid_rst_rdata got=%h want=0", rdata); end
        total++; if (freeze !== 1'b0 || ready !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl got=%b%b%b want=000", freeze, ready, err); end
        @(negedge clk);
        mem_w_en = 1'b0; rst = 1'b1;
        @(negedge clk);
        access(1'b1, 1'b0, 32'd1032, 32'h0, fz, at, e);
        total++; if (rdata !== 32'h0BADF00D) begin bad++; $display("FAIL rst_drops_write got=%h want=0badf00d", rdata); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [3];
        int exp_c [3];
        int k;
        logic adv;
        addrs = '{32'd1024, 32'd1028, 32'd1032};
        exp_c = '{2, 5, 8};
        k = 0;
        r1 = 1'b1; a1 = addrs[0];
        for (int c = 0; c < 12; c++) begin
            #1;
            adv = 1'b0;
            if (ready1) begin
                total++;
                if (k >= 3) begin bad++; $display("FAIL b2b_extra got=cycle %0d want=no pulse", c); end
                else if (c !== exp_c[k]) begin bad++; $display("FAIL b2b_ready got=%0d want=%0d", c, exp_c[k]); end
                total++; if (freeze1 !== 1'b0) begin bad++; $display("FAIL b2b_freeze_done got=%b want=0", freeze1); end
                k++;
                adv = 1'b1;
            end
            @(negedge clk);
            if (adv) begin
                if (k < 3) a1 = addrs[k];
                else r1 = 1'b0;
            end
        end
        total++; if (k !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", k); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_range;
        test_abort;
        test_reset_busy;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
